// File: rtl/mux_n_reg.sv
// N-input selection mux with a registered output stage, pipeline valid/stall/flush
// and a sticky out-of-range selector flag. Per-input use counters: MUX_N_REG_CONTADORES_EN.
module mux_n_reg #(
  parameter int WIDTH         = 32,
  parameter int N_ENTRADAS    = 3,
  parameter int MODO_INVALIDO = 0,
  localparam int SEL_W        = (N_ENTRADAS > 1) ? $clog2(N_ENTRADAS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEL_W-1:0]            seletor,
  input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
  input  logic                        valido_in,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        limpa_erro,
  input  logic [SEL_W-1:0]            cont_idx,
  output logic [WIDTH-1:0]            saida,
  output logic                        valido_out,
  output logic                        erro_sel,
  output logic [15:0]                 cont_val
);

  // Handshake: no ready path. valido_in qualifies seletor/entradas in the cycle it is
  // high; valido_out qualifies saida one cycle later; stall freezes the stage, flush kills it.
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_ENTRADAS);

  logic             in_range;
  logic             carga;
  logic             carga_ok;
  logic             erro_novo;
  logic [WIDTH-1:0] dado_sel;

  // Widened by one bit so the compare stays meaningful when N_ENTRADAS is a power of 2.
  assign in_range  = ({1'b0, seletor} < N_LIM);
  assign carga     = !flush && !stall;
  assign carga_ok  = carga && valido_in && in_range;
  assign erro_novo = carga && valido_in && !in_range;

  always_comb begin
    dado_sel = '0;
    for (int k = 0; k < N_ENTRADAS; k++) begin
      if (seletor == k[SEL_W-1:0]) dado_sel = entradas[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      saida      <= '0;
      valido_out <= 1'b0;
    end else if (flush) begin
      valido_out <= 1'b0;
    end else if (!stall) begin
      if (valido_in && !in_range) begin
        valido_out <= 1'b0;
        if (MODO_INVALIDO == 0) saida <= '0;
      end else begin
        valido_out <= valido_in;
        if (in_range) saida <= dado_sel;
      end
    end
  end

  // A fresh error outranks a clear request in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)          erro_sel <= 1'b0;
    else if (erro_novo)  erro_sel <= 1'b1;
    else if (limpa_erro) erro_sel <= 1'b0;
  end

`ifdef MUX_N_REG_CONTADORES_EN
  logic [15:0] contadores [N_ENTRADAS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_ENTRADAS; k++) contadores[k] <= '0;
    end else begin
      for (int k = 0; k < N_ENTRADAS; k++) begin
        if (carga_ok && (seletor == k[SEL_W-1:0]) && (contadores[k] != 16'hFFFF))
          contadores[k] <= contadores[k] + 16'd1;
      end
    end
  end

  always_comb begin
    cont_val = '0;
    for (int k = 0; k < N_ENTRADAS; k++) begin
      if (cont_idx == k[SEL_W-1:0]) cont_val = contadores[k];
    end
  end
`else
  logic unused_carga_ok;
  assign unused_carga_ok = carga_ok;
  // cont_idx is masked away so the port stays identical without counter storage.
  assign cont_val = 16'h0000 & {{(16-SEL_W){1'b0}}, cont_idx};
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: two instances (MODO_INVALIDO 0 and 1) share stimulus
// and are checked against a rule-level reference model through an expected queue.
module tb_mux_n_reg;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int EW = 1 + 1 + W + W + 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [SW-1:0]  seletor;
  logic [N*W-1:0] entradas;
  logic           valido_in, stall, flush, limpa_erro;
  logic [SW-1:0]  cont_idx;
  logic [W-1:0]   saida0, saida1;
  logic           valido0, valido1, erro0, erro1;
  logic [15:0]    cont0, cont1;

  always #5 clk = ~clk;

  mux_n_reg #(.WIDTH(W), .N_ENTRADAS(N), .MODO_INVALIDO(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .seletor(seletor), .entradas(entradas),
    .valido_in(valido_in), .stall(stall), .flush(flush), .limpa_erro(limpa_erro),
    .cont_idx(cont_idx), .saida(saida0), .valido_out(valido0), .erro_sel(erro0),
    .cont_val(cont0));

  mux_n_reg #(.WIDTH(W), .N_ENTRADAS(N), .MODO_INVALIDO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seletor(seletor), .entradas(entradas),
    .valido_in(valido_in), .stall(stall), .flush(flush), .limpa_erro(limpa_erro),
    .cont_idx(cont_idx), .saida(saida1), .valido_out(valido1), .erro_sel(erro1),
    .cont_val(cont1));

  // Reference model state
  logic [W-1:0] ent [N];
  logic [W-1:0] m_saida0, m_saida1;
  logic         m_valid, m_erro;
  int           m_cnt [N];

  logic [EW-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; model updated from the behavioural rules, result queued.
  task automatic drive(input logic r, input int s, input logic v, input logic st,
                       input logic fl, input logic li, input int idx);
    logic [15:0] e_cont;
    @(negedge clk);
    #1;
    rst_n = r; seletor = s[SW-1:0]; valido_in = v; stall = st; flush = fl;
    limpa_erro = li; cont_idx = idx[SW-1:0];
    for (int k = 0; k < N; k++) entradas[k*W +: W] = ent[k];
    if (!r) begin
      m_saida0 = '0; m_saida1 = '0; m_valid = 1'b0; m_erro = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      if (!fl && !st && v && s >= N) m_erro = 1'b1;
      else if (li) m_erro = 1'b0;
      if (fl) m_valid = 1'b0;
      else if (!st) begin
        if (v && s >= N) begin
          m_valid = 1'b0;
          m_saida0 = '0;
        end else begin
          m_valid = v;
          if (s < N) begin
            m_saida0 = ent[s];
            m_saida1 = ent[s];
            if (v && m_cnt[s] < 65535) m_cnt[s] = m_cnt[s] + 1;
          end
        end
      end
    end
`ifdef MUX_N_REG_CONTADORES_EN
    e_cont = (idx < N) ? 16'(m_cnt[idx]) : 16'h0;
`else
    e_cont = 16'h0;
`endif
    @(posedge clk);
    exp_q.push_back({m_erro, m_valid, m_saida1, m_saida0, e_cont});
  endtask

  // Monitor: every output cycle is compared against the oldest expectation.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("saida_modo0", saida0, e[16 +: W]);
      chk("saida_modo1", saida1, e[16+W +: W]);
      chk("valido_modo0", {31'b0, valido0}, {31'b0, e[EW-2]});
      chk("valido_modo1", {31'b0, valido1}, {31'b0, e[EW-2]});
      chk("erro_modo0", {31'b0, erro0}, {31'b0, e[EW-1]});
      chk("erro_modo1", {31'b0, erro1}, {31'b0, e[EW-1]});
      chk("cont_val0", {16'b0, cont0}, {16'b0, e[15:0]});
      chk("cont_val1", {16'b0, cont1}, {16'b0, e[15:0]});
    end
  end

  initial begin
    rst_n = 1'b0; seletor = '0; valido_in = 1'b0; stall = 1'b0; flush = 1'b0;
    limpa_erro = 1'b0; cont_idx = '0; entradas = '0;
    m_saida0 = '0; m_saida1 = '0; m_valid = 1'b0; m_erro = 1'b0;
    for (int k = 0; k < N; k++) begin ent[k] = $urandom; m_cnt[k] = 0; end

    // Reset with arbitrary inputs, then first load
    drive(0, $urandom_range(0, 3), 1, 0, 0, 1, 0);
    drive(0, $urandom_range(0, 3), 1, 0, 0, 0, 0);
    ent[0] = 32'hA; ent[1] = 32'hB; ent[2] = 32'hC;
    drive(1, 1, 1, 0, 0, 0, 1);
    // Sweep
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 1);
    drive(1, 2, 1, 0, 0, 0, 2);
    // Stall then flush+stall
    drive(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 2, 1, 1, 0, 0, 0);
    drive(1, 2, 1, 1, 1, 0, 0);
    // Invalid selector, sticky flag, clear, collision
    drive(1, 1, 1, 0, 0, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 3);
    drive(1, 0, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 3, 1, 0, 0, 1, 3);
    drive(1, 3, 0, 0, 0, 0, 3);
    drive(1, 0, 0, 0, 0, 1, 0);
    // Counter scenario (all zero when the counter build is off)
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 2, 1, 0, 0, 0, 2);
    drive(1, 2, 1, 1, 0, 0, 2);
    drive(1, 2, 1, 0, 1, 0, 2);
    drive(1, 0, 0, 1, 0, 0, 2);
    drive(1, 0, 0, 1, 0, 0, 3);
    drive(1, 0, 0, 1, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) ent[k] = $urandom;
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 3));
    end
`ifdef MUX_N_REG_CONTADORES_EN
    // Saturation
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
`endif
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-input selection mux with a registered output stage, replacing fixed 3-input combinational forwarding selection in the pipeline.
- Adds pipeline controls: valid, stall and flush.
- Defines behaviour for out-of-range selector values: no X propagation; a sticky error flag is set instead.
- Sits between the forwarding unit and the EX-stage ALU operand register, so it absorbs one pipeline register.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_ENTRADAS, 3, number of inputs; legal range 2..8.
- MODO_INVALIDO, 0, out-of-range selector action: 0 = load zero; 1 = hold previous saida.
- SEL_W, $clog2(N_ENTRADAS), localparam; selector width (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- seletor  input  SEL_W  input index; 0 selects input 0.
- entradas  input  N_ENTRADAS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- valido_in  input  1  input data/selector valid this cycle.
- stall  input  1  hold all registered outputs.
- flush  input  1  kill the stage contents.
- limpa_erro  input  1  clear erro_sel.
- saida  output  WIDTH  registered selected value.
- valido_out  output  1  saida valid.
- erro_sel  output  1  sticky out-of-range selector flag.
- cont_idx  input  SEL_W  counter read index (Optional Feature).
- cont_val  output  16  counter read value (Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk.
  - Reset is synchronous, active low (rst_n=0 sampled at edge).
  - Reset values: saida=0, valido_out=0, erro_sel=0, all counters=0.
- Latency: 1 cycle. Inputs sampled at edge T appear on saida/valido_out after edge T.
- Update priority each edge: reset > flush > stall > load.
  - flush: valido_out<=0. saida keeps its old value. erro_sel is still updated by limpa_erro only.
  - stall (no flush): saida, valido_out and counters hold. erro_sel does not set. limpa_erro is still honoured.
  - load with valido_in=1 and seletor<N_ENTRADAS: saida<=input[seletor], valido_out<=1.
  - load with valido_in=0: valido_out<=0. saida still loads input[seletor] if seletor is in range (don't-care data). No error is raised.
  - load with valido_in=1 and seletor>=N_ENTRADAS:
    - valido_out<=0 and erro_sel<=1.
    - saida<=0 if MODO_INVALIDO=0; holds if MODO_INVALIDO=1.
- erro_sel clearing:
  - limpa_erro=1 clears erro_sel.
  - A simultaneous new error wins: erro_sel=1 after the edge.
- No X ever driven on saida. All selector codes are decoded explicitly.
- When N_ENTRADAS is a power of 2, the out-of-range branch is unreachable and must still synthesize cleanly.
- stall and flush asserted together: flush wins.
- Comparisons are unsigned; seletor is never sign-extended.

Optional Feature:
- Macro: MUX_N_REG_CONTADORES_EN.
- Defined:
  - One 16-bit saturating counter per input, incremented on each accepted load (not stall, not flush, valido_in=1, seletor in range) for the selected input.
  - Counters saturate at 0xFFFF with no wrap. Reset clears them.
  - cont_val = counter[cont_idx], combinational. cont_idx>=N_ENTRADAS reads 0.
- Not defined: no counter storage; cont_val tied to 0; cont_idx ignored.
- Port list is identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles with arbitrary inputs -> saida=0, valido_out=0, erro_sel=0. Then rst_n=1, N=3, entradas={32'hC,32'hB,32'hA}, seletor=1, valido_in=1 -> next cycle saida=0xB, valido_out=1.
- Latency and sweep: seletor 0,1,2 on consecutive cycles -> saida 0xA, 0xB, 0xC one cycle later each, valido_out continuously 1.
- Stall/flush:
  - Load 0xA, then stall=1 for 3 cycles with seletor=2 -> saida stays 0xA, valido_out=1.
  - Then flush=1 with stall=1 -> valido_out=0, saida=0xA.
- Invalid selector, MODO_INVALIDO=0: seletor=3, valido_in=1 after saida=0xB -> saida=0, valido_out=0, erro_sel=1 and stays 1. limpa_erro=1 -> erro_sel=0. Repeat with MODO_INVALIDO=1 -> saida holds 0xB.
- Error clear collision: limpa_erro=1 in the same cycle as seletor=3, valido_in=1 -> erro_sel=1.
- Counters (macro defined):
  - 5 loads of seletor=2, 1 stalled cycle, 1 flushed cycle -> cont_idx=2 gives cont_val=5; cont_idx=3 gives 0.
  - Force 70000 loads of seletor=0 -> cont_val=0xFFFF.
  - Macro undefined -> cont_val=0 throughout.
